// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_W         = 4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_e;
`endif

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// Flops reset high so an idle line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_pin,
  output logic rx_s,
  output logic rx_fall
);

  logic s1, s2, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1   <= rx_pin;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  assign rx_s    = s2;
  assign rx_fall = s2_q & ~s2;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive FSM: start-bit validation, LSB-first data capture, stop check,
// valid/ack handshake with overrun and framing-error pulses.
// Build option: UART_RX_PARITY_EN inserts a PARITY state between DATA and STOP.
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  input  logic                 bps_clk,
  output logic                 count_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun
);

  rx_state_e            state;
  logic                 rx_s, rx_fall;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_ok;
`ifdef UART_RX_PARITY_EN
  logic                 par_err;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_pin  (rx_pin),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

`ifdef UART_RX_PARITY_EN
  assign stop_ok = rx_s & ~par_err;
`else
  assign stop_ok = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count_sig <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_ack) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_fall) begin
            state     <= START;
            count_sig <= 1'b1;
          end
        end

        START: begin
          if (bps_clk) begin
            if (rx_s) begin
              state     <= IDLE;
              count_sig <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (bps_clk) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bps_clk) begin
            par_err <= (rx_s != even_par(8'(shift_reg)));
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (bps_clk) begin
            state     <= IDLE;
            count_sig <= 1'b0;
            if (stop_ok) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
              // Same-cycle ack consumes the old word, so the new one is not an overrun.
              overrun  <= rx_valid & ~rx_ack;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          count_sig <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural baud generator
// (shortened bit period) and a serial-line transmitter task.
module tb_uart_rx_ctrl;

  localparam int DATA_BITS = 8;
  localparam int BIT_CLKS  = 32;
  localparam int HALF      = BIT_CLKS / 2;
  localparam int K_WORD = 0, K_OVR = 1, K_FERR = 2;

  typedef struct {
    int             kind;
    logic [7:0]     data;
    logic           vld;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx_pin = 1'b1;
  logic                 bps_clk;
  logic                 count_sig;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack = 1'b0;
  logic                 frame_err;
  logic                 overrun;

  int   n_chk = 0, n_fail = 0;
  exp_t sb[$];
  logic rv_d = 1'b0, bps_d = 1'b0, fe_d = 1'b0, ov_d = 1'b0;
  logic [7:0] cnt;

  uart_rx_ctrl #(.DATA_BITS(DATA_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_pin    (rx_pin),
    .bps_clk   (bps_clk),
    .count_sig (count_sig),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Baud generator: runs only while count_sig is high, strobes mid-bit.
  always_ff @(posedge clk) begin
    if (rst || !count_sig) cnt <= '0;
    else                   cnt <= (cnt == 8'(BIT_CLKS - 1)) ? 8'd0 : cnt + 8'd1;
  end
  assign bps_clk = count_sig && (cnt == 8'(HALF));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data, input logic vld);
    exp_t e;
    e.kind = kind; e.data = data; e.vld = vld;
    sb.push_back(e);
  endtask

  task automatic pop(input int kind, output exp_t e, output logic ok);
    ok = 1'b0;
    if (sb.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'hFFFF);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      ok = 1'b1;
    end
  endtask

  // Monitor: every delivery/overrun/error event is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (!rst) begin
      if (rx_valid && !rv_d) begin
        pop(K_WORD, e, ok);
        if (ok) chk("word_data", 32'(rx_data), 32'(e.data));
        chk("valid_latency", 32'(bps_d), 32'd1);
        chk("cs_low_after_word", 32'(count_sig), 32'd0);
      end
      if (overrun) begin
        pop(K_OVR, e, ok);
        if (ok) chk("ovr_data", 32'(rx_data), 32'(e.data));
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_one_cycle", 32'(ov_d), 32'd0);
      end
      if (frame_err) begin
        pop(K_FERR, e, ok);
        if (ok) begin
          chk("ferr_data_kept", 32'(rx_data), 32'(e.data));
          chk("ferr_valid", 32'(rx_valid), 32'(e.vld));
        end
        chk("ferr_one_cycle", 32'(fe_d), 32'd0);
      end
    end
    rv_d  = rx_valid;
    bps_d = bps_clk;
    fe_d  = frame_err;
    ov_d  = overrun;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"},   32'(count_sig), 32'd0);
    chk({tag, "_data"}, 32'(rx_data),   32'd0);
    chk({tag, "_vld"},  32'(rx_valid),  32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_ovr"},  32'(overrun),   32'd0);
  endtask

  // Transmit one frame; abort_bit >= 0 pulses rst in the middle of that data bit.
  task automatic send(input logic [7:0] d, input logic stop, input logic par_ok,
                      input int abort_bit);
    @(negedge clk) rx_pin = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_pin = d[i];
      if (i == abort_bit) begin
        idle(HALF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_pin = 1'b1;
        chk_all_zero("after_rst");
        idle(BIT_CLKS * 4);
        chk_all_zero("idle_after_rst");
        return;
      end
      idle(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = (^d) ^ ~par_ok;
    idle(BIT_CLKS);
`else
    if (par_ok) rx_pin = stop;  // parity flag has no effect without the parity bit
`endif
    rx_pin = stop;
    idle(BIT_CLKS);
    rx_pin = 1'b1;
    idle(6);
  endtask

  task automatic ack;
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    chk("valid_clear_after_ack", 32'(rx_valid), 32'd0);
  endtask

  task automatic glitch;
    logic seen;
    seen = 1'b0;
    @(negedge clk) rx_pin = 1'b0;
    idle(3);
    rx_pin = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = count_sig;
    end
    chk("glitch_start_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 2 * BIT_CLKS && count_sig; i++) @(negedge clk);
    chk("glitch_back_idle", 32'(count_sig), 32'd0);
    idle(BIT_CLKS);
    chk("glitch_no_valid", 32'(rx_valid), 32'd0);
    chk("glitch_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    chk_all_zero("reset");

    push(K_WORD, 8'h55, 1'b1);
    send(8'h55, 1'b1, 1'b1, -1);
    chk("w55_cs_low", 32'(count_sig), 32'd0);
    chk("w55_valid", 32'(rx_valid), 32'd1);
    ack();

    glitch();

    push(K_FERR, 8'h55, 1'b0);
    send(8'hA3, 1'b0, 1'b1, -1);
    chk("a3_valid_low", 32'(rx_valid), 32'd0);

    push(K_WORD, 8'h12, 1'b1);
    send(8'h12, 1'b1, 1'b1, -1);
    push(K_OVR, 8'h34, 1'b1);
    send(8'h34, 1'b1, 1'b1, -1);
    chk("ovr_final_data", 32'(rx_data), 32'h34);
    chk("ovr_final_valid", 32'(rx_valid), 32'd1);
    ack();

    send(8'hF8, 1'b1, 1'b1, 3);
    push(K_WORD, 8'hC0, 1'b1);
    send(8'hC0, 1'b1, 1'b1, -1);
    chk("c0_data", 32'(rx_data), 32'hC0);
    ack();

`ifdef UART_RX_PARITY_EN
    push(K_WORD, 8'h07, 1'b1);
    send(8'h07, 1'b1, 1'b1, -1);
    ack();
    push(K_FERR, 8'h07, 1'b0);
    send(8'h07, 1'b1, 1'b0, -1);
    chk("par_bad_valid", 32'(rx_valid), 32'd0);
`endif

    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
